// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// State encoding, counter widths and the index-width helper live here.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int HOLD_W = 8;
  localparam int TURN_W = 4;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    winner
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 off;
  int                 sum;

  // NOTE: every output and temporary gets a default first, so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    dbl    = {req, req};
    rot    = dbl[ptr +: N_REQ];
    off    = 0;
    found  = |rot;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = off + int'(ptr);
    if (sum >= N_REQ) sum = sum - N_REQ;
    winner = IW'(sum);
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter producing registered one-hot enables for a bank of
// tri-state bus drivers, with turnaround gap and maximum hold time.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    owner,
  output logic             bus_busy,
  output logic             hold_timeout
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;

  logic               found;
  logic [IW-1:0]      winner;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .found  (found),
    .winner (winner)
  );

  // Every output is a flop with an asynchronous clear so no buffer can be
  // enabled while reset is held, even before the first clock edge.
  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          owner_d         = winner;
          busy_d          = 1'b1;
          hold_d          = HOLD_W'(1);
        end
      end

      GRANT: begin
        // A dropped request wins over the limit, so a release coinciding
        // with MAX_HOLD is reported as voluntary.
        if (!req[owner_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
          state_d   = TURN;
          gnt_d     = '0;
          owner_d   = '0;
          busy_d    = 1'b0;
          timeout_d = req[owner_q];
          ptr_d     = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
          turn_d    = TURN_W'(1);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      TURN: begin
        if (turn_q == TURN_W'(TURN_CYC)) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign bus_busy     = busy_q;
  assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios followed by
// random request traffic compared against a cycle-level behavioural model.
module tb_bus_arbiter_rr;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 1;
  localparam int BOUND    = N_REQ * (MAX_HOLD + TURN_CYC + 1);

  logic             clk;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       owner;
  logic             bus_busy;
  logic             hold_timeout;

  int n_tests;
  int n_fail;

  // Reference model: who owns the bus, for how long, how many gap cycles
  // remain, and where the next search starts. Owner -1 means nobody.
  int m_owner;
  int m_held;
  int m_wait;
  int m_ptr;
  bit m_timeout;

  int     wait_cnt [N_REQ];
  int     max_wait;
  time    last_rise;

  bus_arbiter_rr #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .gnt          (gnt),
    .owner        (owner),
    .bus_busy     (bus_busy),
    .hold_timeout (hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) last_rise = $time;

  // Enables may only move on a clock rise or while reset is asserted.
  always @(gnt) begin
    check("gnt_edge_source", (reset === 1'b0 || $time == last_rise), 1);
  end

  function automatic logic [N_REQ-1:0] exp_gnt();
    return (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_wait    = 0;
    m_ptr     = 0;
    m_timeout = 0;
  endtask

  task automatic model_edge(input logic [N_REQ-1:0] r);
    m_timeout = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = r[m_owner];
        m_ptr     = (m_owner + 1) % N_REQ;
        m_owner   = -1;
        m_wait    = TURN_CYC;
      end else begin
        m_held++;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N_REQ]) begin
          m_owner = (m_ptr + k) % N_REQ;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("gnt", gnt, exp_gnt());
    check("owner", owner, (m_owner >= 0) ? m_owner : 0);
    check("bus_busy", bus_busy, (m_owner >= 0));
    check("hold_timeout", hold_timeout, m_timeout);
    check("onehot", ($countones(gnt) <= 1), 1);
  endtask

  // Drive req, let one rising edge pass, then compare on the falling edge.
  task automatic cycle(input logic [N_REQ-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    compare_all();
  endtask

  // Called from a point away from the clock edge; releases on a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", bus_busy, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N_REQ-1:0] r;
    n_tests  = 0;
    n_fail   = 0;
    max_wait = 0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    model_reset();

    // Reset held with all requesters active: nothing may be enabled.
    reset = 1'b0;
    req   = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_gnt", gnt, 0);
    check("reset_owner", owner, 0);
    check("reset_busy", bus_busy, 0);
    reset = 1'b1;
    cycle(4'b1111);
    check("first_grant", gnt, 4'b0001);

    // Rotation, hold limit and turnaround with two persistent requesters.
    @(negedge clk);
    apply_reset();
    for (int c = 0; c < 2 * (MAX_HOLD + TURN_CYC + 1) + 4; c++) begin
      cycle(4'b1010);
      if (c == 0) check("rot_first", gnt, 4'b0010);
      if (c == MAX_HOLD) check("rot_timeout", hold_timeout, 1);
      if (c == MAX_HOLD + TURN_CYC + 1) check("rot_second", gnt, 4'b1000);
    end

    // Early release after three cycles, then wrap-around from ptr=3.
    apply_reset();
    repeat (3) cycle(4'b0100);
    cycle(4'b0000);
    check("early_gnt", gnt, 0);
    check("early_timeout", hold_timeout, 0);
    for (int c = 0; c < TURN_CYC + 1; c++) cycle(4'b0011);
    check("wrap_grant", gnt, 4'b0001);

    // Request drops exactly when the hold limit is reached.
    apply_reset();
    repeat (MAX_HOLD) cycle(4'b0001);
    check("simul_held", gnt, 4'b0001);
    cycle(4'b0000);
    check("simul_gnt", gnt, 0);
    check("simul_timeout", hold_timeout, 0);
    repeat (3) cycle(4'b0000);

    // Reset during an active grant must clear enables without a clock.
    apply_reset();
    cycle(4'b0100);
    check("mid_pre", gnt, 4'b0100);
    #2;
    apply_reset();

    // Random traffic with sticky requests so holds and timeouts occur.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      end
      cycle(r);
      for (int i = 0; i < N_REQ; i++) begin
        if (r[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    check("fairness_bound", (max_wait <= BOUND), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for a shared 4-bit bus driven by N_REQ tri-state buffer instances (enable E, data D, output Q).
- Converts per-requester request levels into one-hot, registered buffer enables, so at most one buffer ever drives the bus.
- Inserts a turnaround gap between owners and enforces a maximum hold time.
- Sits between requesting blocks and the enable inputs of the buffer bank.

Parameters:
- N_REQ, 4, number of requesters and buffer instances; legal range 2..8.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus; legal range 1..255.
- TURN_CYC, 1, idle cycles with all enables low between two owners; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request per requester; req[i] high means requester i wants the bus.
- gnt  output  N_REQ  one-hot buffer enables; gnt[i] drives E of buffer i.
- owner  output  clog2(N_REQ)  index of current owner; 0 when bus is idle.
- bus_busy  output  1  high while any gnt bit is high.
- hold_timeout  output  1  one-cycle pulse in the cycle a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (reset low, asynchronous):
  - gnt, owner, bus_busy and hold_timeout all drop to 0 immediately, without waiting for a clock edge.
  - State goes to IDLE; round-robin pointer ptr=0; hold counter=0; turnaround counter=0.
  - The asynchronous clear is mandatory: it guarantees no bus contention during reset.
- All outputs are registered. gnt is never decoded combinationally from req.
- State IDLE:
  - On an edge where req != 0, pick winner w = first set req bit searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next state GRANT. gnt=onehot(w), owner=w, hold counter=1.
  - Latency: req sampled at edge k gives gnt visible after edge k. Each requester sees a one-cycle request-to-grant latency.
  - If req==0, stay in IDLE.
- State GRANT:
  - Each edge where req[owner]=1 and hold counter<MAX_HOLD: stay in GRANT and increment the counter.
  - Edge where req[owner]=0: release. gnt clears after this edge; hold_timeout stays 0.
  - Edge where req[owner]=1 and hold counter==MAX_HOLD: forced release. gnt clears after this edge and hold_timeout pulses for exactly one cycle.
  - On either release: ptr = (owner+1) mod N_REQ; next state TURN with turnaround counter=1.
  - Total grant length with a continuous request is exactly MAX_HOLD cycles.
  - Changes on req bits other than owner are ignored while in GRANT.
- State TURN:
  - All gnt bits are 0 and owner=0.
  - Turnaround counter increments each edge. When it equals TURN_CYC, go to IDLE arbitration on the next edge.
  - The next gnt therefore appears TURN_CYC+1 cycles after the previous gnt fell, inclusive of the IDLE arbitration edge.
  - Requests present during TURN are held off, not lost: they are arbitrated in IDLE.
- Fairness:
  - A timed-out owner that keeps requesting gets lowest priority next, because ptr has moved past it.
  - Any requester holding req high continuously is granted within N_REQ*(MAX_HOLD+TURN_CYC+1) cycles.
- Invariant: popcount(gnt)<=1 in every cycle, including across reset assertion and release.
- Reset deasserted asynchronously mid-cycle takes effect at the next rising edge; the first possible grant is one edge after release.
- owner width is clog2(N_REQ), with a minimum of 1. The hold counter is 8 bits and the turnaround counter is 4 bits; neither may wrap. Saturation is prevented by the parameter ranges.

Decomposition:
- Shared package holds:
  - State encoding IDLE=2'd0, GRANT=2'd1, TURN=2'd2. Encoding 2'd3 is illegal and must recover to IDLE.
  - Counter width constants HOLD_W=8 and TURN_W=4.
  - An index-width function for clog2.
- One combinational sub-module, rr_pick:
  - Inputs req and ptr; outputs found and winner index.
  - Implements the rotate / priority-encode / un-rotate search.
  - Instantiated once by bus_arbiter_rr.

Test Plan:
- Reset behaviour: reset=0 with req=4'b1111 -> gnt=0, owner=0, bus_busy=0. Release reset -> gnt=4'b0001 one edge later.
- Rotation and turnaround: req=4'b1010 held, MAX_HOLD=8, TURN_CYC=1.
  - Expected sequence: gnt=4'b0010 for 8 cycles, then hold_timeout pulse.
  - Then 2 cycles gnt=0, then gnt=4'b1000 for 8 cycles, then back to 4'b0010.
- Early release: req=4'b0100 for 3 cycles, then 0 -> gnt=4'b0100 for exactly 3 cycles, hold_timeout stays 0, ptr=3.
- Wrap-around: ptr=3 with req=4'b0011 -> next grant is 4'b0001, not 4'b0010.
- Simultaneous events: req[owner] falls on the same edge hold counter reaches MAX_HOLD -> treated as normal release, hold_timeout=0, gnt clears once.
- Mid-grant reset and contention check: reset pulled low while gnt=4'b0100 -> gnt=0 with no clock edge. Assertion over the whole run: popcount(gnt)<=1 and no gnt edge other than on clk rise or reset fall.
